// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_pkg
//  Purpose  : Shared types and constants for the seven-segment scan
//             controller and the top-level display wiring.
//  Contents : scan_state_t (FSM states), SEG_OFF (all segments dark),
//             DIG_* digit position indices in seg_in / dig_sel order.
//  Revision : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2,
        GAP  = 2'd3
    } scan_state_t;

    localparam int         SEG_W   = 7;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Digit positions on the shared bus (slot order of the scan).
    localparam int DIG_H1   = 0;
    localparam int DIG_H0   = 1;
    localparam int DIG_M1   = 2;
    localparam int DIG_M0   = 3;
    localparam int DIG_FIR2 = 4;
    localparam int DIG_FIR1 = 5;
    localparam int DIG_FIR0 = 6;

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_timer
//  Purpose  : Loadable down-counter with terminal-count flag. The scan FSM
//             reloads it on each state entry with (phase length - 1); tc is
//             high on the last cycle of the phase.
//  Ports    : clk, rst_n   - clock, asynchronous active-low reset
//             load         - reload count with load_val this edge
//             load_val     - reload value
//             tc           - count has reached zero
//  Revision : 1.0 - initial release
// ============================================================================
module scan_timer
    import seg_scan_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // Saturates at zero so an idle FSM leaves the timer parked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed scan of up to eight seven-segment digits over
//             one shared segment bus. All patterns and blank flags are
//             snapshotted in a single LOAD cycle per frame; each digit is lit
//             for DWELL cycles followed by BLANK all-off cycles.
//  Ports    : clk, rst_n   - clock, asynchronous active-low reset
//             en           - scan enable (sampled in IDLE and at frame end)
//             seg_in       - digit patterns, digit i at [7i+6:7i]
//             blank_mask   - per-digit suppression for the frame
//             seg_out      - shared segment bus, active-high
//             dig_sel      - one-hot digit enable, active-high
//             frame_start  - one-cycle pulse in the LOAD cycle
//             busy         - FSM not in IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIG = 7,
    parameter int DWELL   = 1000,
    parameter int BLANK   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_DIG*SEG_W-1:0] seg_in,
    input  logic [NUM_DIG-1:0]       blank_mask,
    output logic [SEG_W-1:0]         seg_out,
    output logic [NUM_DIG-1:0]       dig_sel,
    output logic                     frame_start,
    output logic                     busy
);

    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BL_W  = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam int CNT_W = (DW_W > BL_W) ? DW_W : BL_W;

    localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_RELOAD = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DIG - 1);
    localparam bit               HAS_GAP      = (BLANK > 0);

    scan_state_t                state;
    scan_state_t                next_state;
    logic [NUM_DIG*SEG_W-1:0]   frame_q;
    logic [NUM_DIG-1:0]         mask_q;
    logic [IDX_W-1:0]           idx;
    logic                       idx_inc;
    logic                       tmr_load;
    logic [CNT_W-1:0]           tmr_val;
    logic                       tmr_tc;

    scan_timer #(
        .WIDTH    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The timer is reloaded on every phase entry,
    // including SHOW->SHOW when there is no gap between digits.
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = DWELL_RELOAD;
        idx_inc    = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state = SHOW;
                tmr_load   = 1'b1;
            end
            SHOW: begin
                if (tmr_tc) begin
                    if (HAS_GAP) begin
                        next_state = GAP;
                        tmr_load   = 1'b1;
                        tmr_val    = BLANK_RELOAD;
                    end else if (idx != LAST_IDX) begin
                        next_state = SHOW;
                        idx_inc    = 1'b1;
                        tmr_load   = 1'b1;
                    end else begin
                        next_state = en ? LOAD : IDLE;
                    end
                end
            end
            GAP: begin
                if (tmr_tc) begin
                    if (idx != LAST_IDX) begin
                        next_state = SHOW;
                        idx_inc    = 1'b1;
                        tmr_load   = 1'b1;
                    end else begin
                        next_state = en ? LOAD : IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame snapshot and digit index. Capture happens on the edge that
    // ends LOAD, so inputs present during LOAD are the ones displayed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            mask_q  <= '0;
            idx     <= '0;
        end else if (state == LOAD) begin
            frame_q <= seg_in;
            mask_q  <= blank_mask;
            idx     <= '0;
        end else if (idx_inc) begin
            idx     <= idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded purely from registered state, so dig_sel is at
    // most one-hot and seg_out is dark whenever no digit is enabled.
    // ------------------------------------------------------------------
    always_comb begin
        seg_out     = SEG_OFF;
        dig_sel     = '0;
        frame_start = (state == LOAD);
        busy        = (state != IDLE);
        if (state == SHOW) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                if ((idx == IDX_W'(i)) && !mask_q[i]) begin
                    dig_sel[i] = 1'b1;
                    seg_out    = frame_q[i*SEG_W +: SEG_W];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Self-checking bench for seg_scan_ctrl. Two instances share
//             clock, reset and data inputs: dut (DWELL=4, BLANK=2) and
//             dut_b (DWELL=4, BLANK=0). Expected outputs come from a
//             frame-timing model: cycle t of a frame maps to slot
//             (t-1)/(DWELL+BLANK), lit for the first DWELL cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int N      = 7;
    localparam int DW     = 4;
    localparam int BL     = 2;
    localparam int FRAME  = N * (DW + BL) + 1;
    localparam int FRAME0 = N * DW + 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          en    = 1'b0;
    logic          en_b  = 1'b0;
    logic [48:0]   seg_in = '0;
    logic [6:0]    blank_mask = '0;

    logic [6:0]    seg_out,  seg_out_b;
    logic [6:0]    dig_sel,  dig_sel_b;
    logic          frame_start, frame_start_b;
    logic          busy, busy_b;
    logic [15:0]   obs, obs_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign obs   = {frame_start,   busy,   dig_sel,   seg_out};
    assign obs_b = {frame_start_b, busy_b, dig_sel_b, seg_out_b};

    seg_scan_ctrl #(.NUM_DIG(N), .DWELL(DW), .BLANK(BL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .seg_in      (seg_in),
        .blank_mask  (blank_mask),
        .seg_out     (seg_out),
        .dig_sel     (dig_sel),
        .frame_start (frame_start),
        .busy        (busy)
    );

    seg_scan_ctrl #(.NUM_DIG(N), .DWELL(DW), .BLANK(0)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en_b),
        .seg_in      (seg_in),
        .blank_mask  (blank_mask),
        .seg_out     (seg_out_b),
        .dig_sel     (dig_sel_b),
        .frame_start (frame_start_b),
        .busy        (busy_b)
    );

    // Expected {frame_start, busy, dig_sel, seg_out} at cycle t of a frame
    // (t=0 is the LOAD cycle); past the last slot the scanner is idle.
    function automatic logic [15:0] model(int t, logic [48:0] snap, logic [6:0] msk, int blank);
        int s;
        int p;
        logic [6:0] d;
        logic [6:0] sg;
        if (t == 0) return {1'b1, 1'b1, 7'd0, 7'd0};
        s = (t - 1) / (DW + blank);
        p = (t - 1) % (DW + blank);
        if (s >= N) return 16'd0;
        d  = '0;
        sg = '0;
        if (p < DW && !msk[s]) begin
            d[s] = 1'b1;
            sg   = snap[7*s +: 7];
        end
        return {1'b0, 1'b1, d, sg};
    endfunction

    function automatic logic [48:0] rnd49();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[48:0];
    endfunction

    // Bus invariants on both instances, every cycle.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(dig_sel) || (dig_sel == 7'd0 && seg_out != 7'd0)) begin
            errors++;
            $display("FAIL bus_invariant dig_sel=%b seg_out=%h", dig_sel, seg_out);
        end
        checks++;
        if (!$onehot0(dig_sel_b) || (dig_sel_b == 7'd0 && seg_out_b != 7'd0)) begin
            errors++;
            $display("FAIL bus_invariant_b dig_sel=%b seg_out=%h", dig_sel_b, seg_out_b);
        end
    end

    task automatic test_reset();
        #2 rst_n = 1'b0;
        seg_in = rnd49();
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 16'd0 || obs_b !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got %h/%h exp 0000", obs, obs_b);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seg_in = rnd49();
            checks++;
            if (obs !== 16'd0 || obs_b !== 16'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got %h/%h exp 0000", i, obs, obs_b);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [48:0] snap;
        int fs;
        @(negedge clk);
        seg_in = rnd49(); blank_mask = '0; en = 1'b1;
        @(negedge clk);
        en = 1'b0; seg_in = rnd49(); snap = seg_in; fs = 0;
        for (int t = 0; t < FRAME + 6; t++) begin
            if (t > 0) @(negedge clk);
            checks++;
            if (obs !== model(t, snap, 7'd0, BL)) begin
                errors++;
                $display("FAIL single_frame t=%0d got %h exp %h", t, obs, model(t, snap, 7'd0, BL));
            end
            if (frame_start) fs++;
            if (t > 0) begin seg_in = rnd49(); blank_mask = 7'($urandom()); end
        end
        checks++;
        if (fs != 1) begin
            errors++;
            $display("FAIL single_frame_pulses got %0d exp 1", fs);
        end
        blank_mask = '0;
    endtask

    task automatic test_reset_mid_show();
        logic [48:0] snap;
        @(negedge clk);
        en = 1'b1; blank_mask = '0;
        @(negedge clk);
        en = 1'b0; seg_in = rnd49() | 49'h1; snap = seg_in;
        for (int t = 0; t <= 20; t++) begin
            if (t > 0) @(negedge clk);
            checks++;
            if (obs !== model(t, snap, 7'd0, BL)) begin
                errors++;
                $display("FAIL mid_show_run t=%0d got %h exp %h", t, obs, model(t, snap, 7'd0, BL));
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 16'd0) begin
            errors++;
            $display("FAIL reset_async got %h exp 0000", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seg_in = rnd49();
            checks++;
            if (obs !== 16'd0) begin
                errors++;
                $display("FAIL reset_release_idle cyc=%0d got %h exp 0000", i, obs);
            end
        end
    endtask

    // en held high for three frames; it drops in the LOAD cycle of the last
    // frame together with a fresh seg_in/blank_mask, which must be captured.
    task automatic test_continuous();
        logic [48:0] snap;
        logic [6:0]  msk;
        int t, f, last_fs, nfs;
        snap = '0; msk = '0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        t = 0; f = 0; last_fs = -1; nfs = 0;
        for (int cyc = 0; cyc < 3 * FRAME + 5; cyc++) begin
            if (cyc > 0) @(negedge clk);
            checks++;
            if (obs !== model(t, snap, msk, BL)) begin
                errors++;
                $display("FAIL continuous cyc=%0d t=%0d got %h exp %h", cyc, t, obs, model(t, snap, msk, BL));
            end
            if (frame_start) begin
                nfs++;
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != FRAME) begin
                        errors++;
                        $display("FAIL frame_period got %0d exp %0d", cyc - last_fs, FRAME);
                    end
                end
                last_fs = cyc;
            end
            seg_in = rnd49();
            blank_mask = 7'($urandom());
            if (t == 0) begin
                snap = seg_in; msk = blank_mask;
                if (f == 2) en = 1'b0;
            end
            t++;
            if (t == FRAME && f < 2) begin t = 0; f++; end
        end
        checks++;
        if (nfs != 3) begin
            errors++;
            $display("FAIL continuous_pulses got %0d exp 3", nfs);
        end
        blank_mask = '0;
    endtask

    task automatic test_snapshot();
        logic [48:0] snap;
        int t, f;
        @(negedge clk);
        en = 1'b1; blank_mask = '0;
        @(negedge clk);
        seg_in = {rnd49() >> 7, 7'h3F};
        snap = seg_in; t = 0; f = 0;
        for (int cyc = 0; cyc < 2 * FRAME + 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            checks++;
            if (obs !== model(t, snap, 7'd0, BL)) begin
                errors++;
                $display("FAIL snapshot cyc=%0d got %h exp %h", cyc, obs, model(t, snap, 7'd0, BL));
            end
            if (cyc == 1) begin
                checks++;
                if (seg_out !== 7'h3F) begin
                    errors++;
                    $display("FAIL snapshot_old got %h exp 3f", seg_out);
                end
            end
            if (cyc == FRAME + 1) begin
                checks++;
                if (seg_out !== 7'h06) begin
                    errors++;
                    $display("FAIL snapshot_new got %h exp 06", seg_out);
                end
            end
            if (f == 0 && t == 13) seg_in[6:0] = 7'h06;
            if (f == 1 && t == 0) begin snap = seg_in; en = 1'b0; end
            t++;
            if (t == FRAME && f == 0) begin t = 0; f = 1; end
        end
    endtask

    task automatic test_blanking();
        logic [48:0] snap;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0; seg_in = rnd49(); blank_mask = 7'b0000001; snap = seg_in;
        for (int t = 0; t < FRAME + 3; t++) begin
            if (t > 0) @(negedge clk);
            checks++;
            if (obs !== model(t, snap, 7'b0000001, BL)) begin
                errors++;
                $display("FAIL blanking t=%0d got %h exp %h", t, obs, model(t, snap, 7'b0000001, BL));
            end
            if (t >= 1 && t <= 4) begin
                checks++;
                if (dig_sel !== 7'd0 || seg_out !== 7'd0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL blank_slot t=%0d got %b/%h exp 0/00", t, dig_sel, seg_out);
                end
            end
            if (t == 7) begin
                checks++;
                if (dig_sel !== 7'b0000010) begin
                    errors++;
                    $display("FAIL blank_next_offset got %b exp 0000010", dig_sel);
                end
            end
            if (t > 0) blank_mask = 7'($urandom());
        end
        blank_mask = '0;
    endtask

    task automatic test_no_gap();
        logic [48:0] snap;
        logic [6:0]  msk;
        int t, f, last_fs;
        @(negedge clk);
        en_b = 1'b1;
        @(negedge clk);
        t = 0; f = 0; last_fs = -1;
        seg_in = rnd49(); blank_mask = 7'($urandom()); snap = seg_in; msk = blank_mask;
        for (int cyc = 0; cyc < 2 * FRAME0 + 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            checks++;
            if (obs_b !== model(t, snap, msk, 0)) begin
                errors++;
                $display("FAIL no_gap cyc=%0d got %h exp %h", cyc, obs_b, model(t, snap, msk, 0));
            end
            if (frame_start_b) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != FRAME0) begin
                        errors++;
                        $display("FAIL no_gap_period got %0d exp %0d", cyc - last_fs, FRAME0);
                    end
                end
                last_fs = cyc;
            end
            if (cyc > 0) begin
                seg_in = rnd49(); blank_mask = 7'($urandom());
                if (t == 0) begin snap = seg_in; msk = blank_mask; en_b = 1'b0; end
            end
            t++;
            if (t == FRAME0 && f == 0) begin t = 0; f = 1; end
        end
        checks++;
        if (last_fs != FRAME0) begin
            errors++;
            $display("FAIL no_gap_second_frame got %0d exp %0d", last_fs, FRAME0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_reset_mid_show();
        test_continuous();
        test_snapshot();
        test_blanking();
        test_no_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
